// File: rtl/counter_pkg.sv
// Shared definitions for the loadable counter: default parameter values and
// the next-state selector used by the counter datapath and its assertions.
package counter_pkg;

  localparam int unsigned COUNTER_DEFAULT_WIDTH   = 8;
  localparam int unsigned COUNTER_DEFAULT_RST_VAL = 0;

  // Which source feeds the count register at the next rising edge.
  typedef enum logic [1:0] {
    HOLD = 2'd0,
    LOAD = 2'd1,
    INCR = 2'd2
  } counter_sel_e;

endpackage : counter_pkg

// File: rtl/loadable_counter.sv
// Synchronous up-counter with parallel load (priority) and count enable.
// Default build: count wraps modulo 2^WIDTH and wrap pulses for one cycle
// after an increment from all-ones.
// Optional build macro LOADABLE_COUNTER_SATURATE_EN: increments stop at
// all-ones and wrap becomes a level "saturated" flag, cleared by load/reset.
// Both outputs come straight from registers; no input reaches an output
// combinationally.
module loadable_counter
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH   = COUNTER_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(COUNTER_DEFAULT_RST_VAL)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  counter_sel_e     sel_d;
  logic [WIDTH-1:0] count_d, count_q;
  logic             wrap_d, wrap_q;

  // Select the next-state source: load beats enable, otherwise hold.
  always_comb begin
    sel_d = HOLD;
    if (load) begin
      sel_d = LOAD;
    end else if (enable) begin
      sel_d = INCR;
    end
  end

  // Compute next count and next wrap/saturated flag from the selected source.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    case (sel_d)
      LOAD: begin
        // A load never raises the flag, whatever value is loaded.
        count_d = data_in;
        wrap_d  = 1'b0;
      end
      INCR: begin
`ifdef LOADABLE_COUNTER_SATURATE_EN
        count_d = (count_q == ALL_ONES) ? count_q : count_q + WIDTH'(1);
        wrap_d  = (count_d == ALL_ONES);
`else
        count_d = count_q + WIDTH'(1);
        wrap_d  = (count_q == ALL_ONES);
`endif
      end
      HOLD: begin
`ifdef LOADABLE_COUNTER_SATURATE_EN
        // Saturated flag is a level: it persists while the count sits still.
        wrap_d = wrap_q;
`else
        wrap_d = 1'b0;
`endif
      end
      default: begin
        count_d = count_q;
        wrap_d  = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RST_VAL;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

`ifndef SYNTHESIS
  // A load request always lands data_in, regardless of enable.
  a_load_priority: assert property (
    @(posedge clk) disable iff (!rst_n)
    load |=> (count == $past(data_in))
  ) else $error("load did not take priority over enable");

`ifndef LOADABLE_COUNTER_SATURATE_EN
  // The wrap indication lasts exactly one cycle.
  a_wrap_pulse: assert property (
    @(posedge clk) disable iff (!rst_n)
    wrap |=> !wrap
  ) else $error("wrap held for more than one cycle");
`endif
`endif

endmodule : loadable_counter

// File: tb/tb_loadable_counter.sv
// Directed and model-checked bench for loadable_counter (WIDTH=8, RST_VAL=0).
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_loadable_counter;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] data_in;
  logic         load;
  logic         enable;
  logic [W-1:0] count;
  logic         wrap;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state for the randomized run
  logic [W-1:0] exp_cnt;
  logic         exp_wrap;

  loadable_counter #(.WIDTH(W), .RST_VAL('0)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_in (data_in),
    .load    (load),
    .enable  (enable),
    .count   (count),
    .wrap    (wrap)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs may change and outputs are settled afterwards
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic en, input logic [W-1:0] d);
    load    = ld;
    enable  = en;
    data_in = d;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0);
    #1;
    check_eq("por_count", count, 8'h00);
    check_eq("por_wrap",  wrap,  1'b0);
    step();
    rst_n = 1'b1;

    // 1. asynchronous reset mid-cycle from 0x37
    drive(1'b1, 1'b0, 8'h37);
    step();
    drive(1'b0, 1'b0, 8'h00);
    check_eq("pre_rst_count", count, 8'h37);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_count", count, 8'h00);
    check_eq("async_rst_wrap",  wrap,  1'b0);
    drive(1'b1, 1'b1, 8'hAA);  // ignored while in reset
    step();
    check_eq("rst_hold_count", count, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    step();
    check_eq("rst_release_count", count, 8'h00);
    step();
    check_eq("rst_idle_count", count, 8'h00);

    // 2. load 0xDE then hold
    drive(1'b1, 1'b0, 8'hDE);
    step();
    check_eq("load_count", count, 8'hDE);
    check_eq("load_wrap",  wrap,  1'b0);
    drive(1'b0, 1'b0, 8'h00);
    step();
    check_eq("hold_count", count, 8'hDE);

    // 3. three increments
    drive(1'b0, 1'b1, 8'h00);
    step(); check_eq("incr1", count, 8'hDF);
    step(); check_eq("incr2", count, 8'hE0);
    step(); check_eq("incr3", count, 8'hE1);

    // 4. wrap / saturate at all-ones
    drive(1'b1, 1'b0, 8'hFF);
    step();
    check_eq("load_ff_count", count, 8'hFF);
    check_eq("load_ff_wrap",  wrap,  1'b0);
    drive(1'b0, 1'b1, 8'h00);
    step();
`ifdef LOADABLE_COUNTER_SATURATE_EN
    check_eq("sat_count1", count, 8'hFF);
    check_eq("sat_flag1",  wrap,  1'b1);
    step();
    check_eq("sat_count2", count, 8'hFF);
    check_eq("sat_flag2",  wrap,  1'b1);
    drive(1'b0, 1'b0, 8'h00);
    step();
    check_eq("sat_hold_flag", wrap, 1'b1);
    drive(1'b1, 1'b0, 8'h00);
    step();
    check_eq("sat_load_clr", wrap, 1'b0);
`else
    check_eq("wrap_count", count, 8'h00);
    check_eq("wrap_pulse", wrap,  1'b1);
    step();
    check_eq("post_wrap_count", count, 8'h01);
    check_eq("post_wrap_wrap",  wrap,  1'b0);
    drive(1'b1, 1'b0, 8'h00);  // load of zero must not flag
    step();
    check_eq("load_zero_wrap", wrap, 1'b0);
`endif

    // reset while wrap is high clears it immediately
    drive(1'b1, 1'b0, 8'hFF);
    step();
    drive(1'b0, 1'b1, 8'h00);
    step();
    check_eq("pre_rst_wrap", wrap, 1'b1);
    drive(1'b0, 1'b0, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_clr_wrap",  wrap,  1'b0);
    check_eq("rst_clr_count", count, 8'h00);
    step();
    rst_n = 1'b1;

    // 5. simultaneous load and enable: load wins
    drive(1'b1, 1'b0, 8'h10);
    step();
    drive(1'b1, 1'b1, 8'h5A);
    step();
    check_eq("simul_count", count, 8'h5A);
    check_eq("simul_wrap",  wrap,  1'b0);

    // randomized run against a cycle-level model
    exp_cnt  = 8'h5A;
    exp_wrap = 1'b0;
    for (int i = 0; i < 200; i++) begin
      logic         r_ld, r_en;
      logic [W-1:0] r_d;
      r_ld = ($urandom_range(0, 5) == 0);
      r_en = ($urandom_range(0, 3) != 0);
      r_d  = ($urandom_range(0, 1) == 0) ? W'($urandom_range(240, 255)) : W'($urandom_range(0, 255));
      drive(r_ld, r_en, r_d);
      if (r_ld) begin
        exp_cnt  = r_d;
        exp_wrap = 1'b0;
      end else if (r_en) begin
`ifdef LOADABLE_COUNTER_SATURATE_EN
        if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'h01;
        exp_wrap = (exp_cnt == 8'hFF);
`else
        exp_wrap = (exp_cnt == 8'hFF);
        exp_cnt  = exp_cnt + 8'h01;
`endif
      end else begin
`ifndef LOADABLE_COUNTER_SATURATE_EN
        exp_wrap = 1'b0;
`endif
      end
      step();
      check_eq("rand_count", count, exp_cnt);
      check_eq("rand_wrap",  wrap,  exp_wrap);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_loadable_counter
